// File: rtl/gray_conv_arbiter.sv
// Four-requester round-robin arbiter feeding one Gray-to-binary converter.
// A word is captured in IDLE, converted in CONV, and held in HOLD until accepted.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] gray_in,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   bin_out,
  output logic [1:0]         bin_id,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic               busy
);

  // Handshake: the result is offered while bin_valid is high and is consumed
  // on the first rising edge where bin_valid && bin_ready; outputs are frozen
  // until then, and bin_ready has no effect while bin_valid is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]   bin_out_q, bin_out_d;
  logic [1:0]         bin_id_q, bin_id_d;
  logic               bin_valid_q, bin_valid_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // First asserted request found walking upward from ptr, modulo 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    word_d      = word_q;
    idx_d       = idx_q;
    bin_out_d   = bin_out_q;
    bin_id_d    = bin_id_q;
    bin_valid_d = bin_valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          word_d  = gray_in[win_idx*WIDTH +: WIDTH];
          idx_d   = win_idx;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_out_d   = gray2bin(word_q);
        bin_id_d    = idx_q;
        bin_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bin_ready) begin
          bin_valid_d = 1'b0;
          ptr_d       = bin_id_q + 2'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        bin_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      bin_out_q   <= '0;
      bin_id_q    <= '0;
      bin_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      bin_out_q   <= bin_out_d;
      bin_id_q    <= bin_id_d;
      bin_valid_q <= bin_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign bin_out   = bin_out_q;
  assign bin_id    = bin_id_q;
  assign bin_valid = bin_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized bench for gray_conv_arbiter against a transaction-level model
// of the round-robin pointer and prefix-XOR Gray decoding.
module tb_gray_conv_arbiter;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] gray_in;
  logic [3:0]     gnt;
  logic [W-1:0]   bin_out;
  logic [1:0]     bin_id;
  logic           bin_valid;
  logic           bin_ready;
  logic           busy;

  int total;
  int bad;
  int m_ptr;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .gnt(gnt),
    .bin_out(bin_out), .bin_id(bin_id), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    logic [W-1:0] t;
    b = '0;
    t = g;
    while (t != 0) begin
      b = b ^ t;
      t = t >> 1;
    end
    return b;
  endfunction

  function automatic int m_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({gnt, bin_valid, bin_out, bin_id, busy} !== '0) begin
      bad++;
      $display("FAIL %s: gnt=%b valid=%b out=%b id=%0d busy=%b, required all zero",
               name, gnt, bin_valid, bin_out, bin_id, busy);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    bin_ready = 1'b0;
    gray_in = 16'($urandom);
    #1;
    check_all_zero("reset_async");
    step();
    step();
    check_all_zero("reset_clocked");
    #2 rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // One full transaction; the model predicts winner, grant and result.
  task automatic do_txn(input logic [3:0] r, input logic [4*W-1:0] g, input int hold);
    int            wid;
    logic [3:0]    exp_gnt;
    logic [W-1:0]  exp_bin;
    wid = m_winner(r, m_ptr);
    exp_gnt = 4'b0001 << wid;
    exp_bin = m_g2b(g[wid*W +: W]);
    req = r;
    gray_in = g;
    step();
    total++;
    if ({gnt, busy, bin_valid} !== {exp_gnt, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL grant: gnt=%b busy=%b valid=%b, required gnt=%b busy=1 valid=0",
               gnt, busy, bin_valid, exp_gnt);
    end
    req = 4'($urandom);
    gray_in = 16'($urandom);
    bin_ready = 1'($urandom);
    step();
    total++;
    if ({gnt, bin_valid, bin_out, bin_id} !== {4'b0, 1'b1, exp_bin, 2'(wid)}) begin
      bad++;
      $display("FAIL result: gnt=%b valid=%b out=%b id=%0d, required gnt=0000 valid=1 out=%b id=%0d",
               gnt, bin_valid, bin_out, bin_id, exp_bin, wid);
    end
    for (int h = 0; h < hold; h++) begin
      req = 4'($urandom);
      gray_in = 16'($urandom);
      bin_ready = 1'b0;
      step();
      total++;
      if ({gnt, busy, bin_valid, bin_out, bin_id} !== {4'b0, 1'b1, 1'b1, exp_bin, 2'(wid)}) begin
        bad++;
        $display("FAIL hold: gnt=%b busy=%b valid=%b out=%b id=%0d, required 0000/1/1/%b/%0d",
                 gnt, busy, bin_valid, bin_out, bin_id, exp_bin, wid);
      end
    end
    req = 4'($urandom);
    gray_in = 16'($urandom);
    bin_ready = 1'b1;
    step();
    total++;
    if ({gnt, busy, bin_valid} !== 6'b0) begin
      bad++;
      $display("FAIL complete: gnt=%b busy=%b valid=%b, required all zero", gnt, busy, bin_valid);
    end
    m_ptr = (wid + 1) % 4;
    req = '0;
    bin_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      req = '0;
      bin_ready = 1'($urandom);
      gray_in = 16'($urandom);
      step();
      total++;
      if ({gnt, busy, bin_valid} !== 6'b0) begin
        bad++;
        $display("FAIL idle: gnt=%b busy=%b valid=%b, required all zero", gnt, busy, bin_valid);
      end
    end
    bin_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [4*W-1:0] g;
    g = 16'($urandom);
    g[3:0] = 4'b1011;
    do_txn(4'b0001, g, 0);
  endtask

  task automatic test_sweep();
    logic [W-1:0]   words [4];
    logic [4*W-1:0] g;
    words[0] = 4'b0000; words[1] = 4'b1000; words[2] = 4'b0110; words[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      g = 16'($urandom);
      g[8 +: 4] = words[i];
      do_txn(4'b0100, g, 0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ((4'b0001 << m_winner(4'b1111, m_ptr)) !== order[i]) begin
        bad++;
        $display("FAIL rr_order: model grant idx=%0d, required %b", m_winner(4'b1111, m_ptr), order[i]);
      end
      do_txn(4'b1111, 16'($urandom), 0);
    end
  endtask

  task automatic test_backpressure();
    do_txn(4'($urandom_range(1, 15)), 16'($urandom), 5);
    test_idle();
  endtask

  task automatic test_mid_reset();
    req = 4'b0100;
    gray_in = 16'($urandom);
    step();
    req = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_conv");
    step();
    check_all_zero("reset_in_conv_clk");
    #2 rst_n = 1'b1;
    req = 4'b0010;
    step();
    req = '0;
    step();
    total++;
    if (bin_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_entry: valid=%b, required 1", bin_valid);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_hold");
    #2 rst_n = 1'b1;
    m_ptr = 0;
    bin_ready = 1'b1;
    step();
    check_all_zero("after_abort");
    bin_ready = 1'b0;
    do_txn(4'b0100, 16'($urandom), 1);
  endtask

  task automatic test_priority();
    do_txn(4'b0010, 16'($urandom), 0);
    do_txn(4'b0011, 16'($urandom), 0);
    do_txn(4'b0011, 16'($urandom), 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(4'($urandom_range(1, 15)), 16'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) test_idle();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_ptr = 0;
    rst_n = 1'b0;
    req = '0;
    gray_in = '0;
    bin_ready = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_sweep();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter SHALL be: WIDTH, default 4, Gray/binary word width in bits (minimum 2).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  4  per-requester conversion request; bit i belongs to requester i.
REQ-006 Port: gray_in  input  4*WIDTH  requester i Gray word at bits [i*WIDTH +: WIDTH]; MSB is the highest-index bit.
REQ-007 Port: gnt  output  4  one-hot grant; bit i is high for exactly one cycle when requester i's word is captured.
REQ-008 Port: bin_out  output  WIDTH  converted binary result.
REQ-009 Port: bin_id  output  2  index of the requester that owns bin_out.
REQ-010 Port: bin_valid  output  1  bin_out and bin_id are valid.
REQ-011 Port: bin_ready  input  1  consumer accepts the result.
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CONV and HOLD, with all outputs registered.
REQ-014 IDLE: if req != 0 at a clock edge, the FSM SHALL select the winner, capture that requester's gray_in slice and index, set gnt[winner]=1, and move to CONV.
REQ-015 IDLE with req == 0: the FSM SHALL stay in IDLE with gnt=0.
REQ-016 Arbitration SHALL be round-robin: search order starts at ptr and proceeds ptr, ptr+1, ... modulo 4; the first asserted req bit wins.
REQ-017 CONV: at the next edge the FSM SHALL clear gnt, load bin_out with the conversion of the captured word, load bin_id, set bin_valid=1, and move to HOLD.
REQ-018 Conversion rule SHALL be: b[WIDTH-1]=g[WIDTH-1]; for i from WIDTH-2 down to 0, b[i]=b[i+1] XOR g[i].
REQ-019 HOLD: bin_valid, bin_out and bin_id SHALL stay stable until bin_ready is sampled high.
REQ-020 At that edge the FSM SHALL clear bin_valid, set ptr = (bin_id+1) mod 4, and return to IDLE.
REQ-021 Latency SHALL be 2 cycles from the edge that samples req to bin_valid high; minimum transaction spacing is 3 cycles.
REQ-022 bin_ready SHALL be ignored outside HOLD.
REQ-023 req and gray_in SHALL be ignored in CONV and HOLD; only the word captured in IDLE is converted.
REQ-024 A requester that keeps req high after its gnt SHALL be treated as a new request at the next IDLE arbitration.
REQ-025 If several req bits are high simultaneously, exactly one gnt bit SHALL be set, per REQ-016.
REQ-026 Grant order SHALL guarantee that each continuously asserted requester is served within 4 transactions.
REQ-027 ptr SHALL wrap from 3 to 0.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 While rst_n=0, regardless of clock, the block SHALL force: state=IDLE, ptr=0, gnt=0, bin_valid=0, bin_out=0, bin_id=0, busy=0.
REQ-030 Reset asserted in CONV or HOLD SHALL abort the transaction; no result is delivered for it.
REQ-031 After reset release, the first arbitration SHALL start at requester 0.

Verification
REQ-032 Single request: WIDTH=4, req=0001, gray slice 0 = 1011.
  -> gnt=0001 for 1 cycle; 2 cycles after sampling, bin_valid=1, bin_out=1101, bin_id=0.
REQ-033 Conversion sweep on requester 2: gray 0000, 1000, 0110, 0001, with bin_ready tied high.
  -> bin_out 0000, 1111, 0100, 0001, bin_id=2 each time.
REQ-034 Round-robin: req=1111 held, bin_ready tied high.
  -> grants 0001, 0010, 0100, 1000, 0001 in that order; ptr wraps 3 to 0.
REQ-035 Backpressure: bin_ready=0 for 5 cycles in HOLD, with req toggling and gray_in changing.
  -> bin_valid, bin_out and bin_id stay stable; no gnt is issued; exactly one completion when bin_ready=1.
REQ-036 Mid-operation reset: rst_n low during CONV, then during HOLD.
  -> all outputs 0 immediately; next request req=0100 with ptr restarted at 0 grants 0100.
REQ-037 Priority after completion: serve requester 1, then assert req=0011.
  -> requester 0 is granted before requester 1 (ptr=2 wraps to 0).
